// File: rtl/instr_encoder.sv
// Streaming micro-op to instruction-word encoder.
// Emits encoded words with sequential load addresses.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic              out_last;

  logic [5:0]  funct;
  logic [5:0]  opc;
  logic        is_r;
  logic        is_ill;
  logic        rt_rs2;
  logic [31:0] enc;
  logic        accept;
  logic        hs;

  always_comb begin
    is_r   = ~in_op[3];
    is_ill = &in_op;
    rt_rs2 = (in_op == 4'd13) || (in_op == 4'd14);
    funct  = 6'd0;
    unique case (in_op[2:0])
      3'd0: funct = 6'b100000;
      3'd1: funct = 6'b100010;
      3'd2: funct = 6'b100100;
      3'd3: funct = 6'b100101;
      3'd4: funct = 6'b100110;
      3'd5: funct = 6'b000100;
      3'd6: funct = 6'b000110;
      3'd7: funct = 6'b011000;
    endcase
    opc = 6'd0;
    case (in_op)
      4'd8:    opc = 6'b001000;
      4'd9:    opc = 6'b001100;
      4'd10:   opc = 6'b001101;
      4'd11:   opc = 6'b001110;
      4'd12:   opc = 6'b100011;
      4'd13:   opc = 6'b101011;
      4'd14:   opc = 6'b000100;
      default: opc = 6'd0;
    endcase
    // SW and BEQ carry rs2 in the rt slot, the rest of I-type carry rd
    enc = {opc, in_rs1, in_rd, in_imm};
    unique case (1'b1)
      is_r:    enc = {6'd0, in_rs1, in_rs2, in_rd, 5'd0, funct};
      rt_rs2:  enc = {opc, in_rs1, in_rs2, in_imm};
      default: ;
    endcase
  end

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      next_addr   <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_instr   <= '0;
      out_last    <= 1'b0;
      err_illegal <= 1'b0;
      err_wrap    <= 1'b0;
      count       <= '0;
    end else begin
      if (hs) begin
        out_valid <= 1'b0;
        count     <= count + 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            next_addr   <= base_addr;
            count       <= '0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
          end
        end
        S_RUN: begin
          if (hs && out_last)
            state <= S_DONE;
          if (accept && is_ill) begin
            err_illegal <= 1'b1;
            if (in_last)
              state <= S_DONE;
          end
          if (accept && !is_ill) begin
            out_valid <= 1'b1;
            out_instr <= enc;
            out_addr  <= next_addr;
            out_last  <= in_last;
            next_addr <= next_addr + 1'b1;
            if (&next_addr)
              err_wrap <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder: turns symbolic micro-op requests (operation, register numbers, immediate) into 32-bit instruction words in the exact opcode/funct format the core's control decoder accepts. It then emits them with sequential addresses for loading into instruction memory. It sits between the test/boot program source and the instruction-memory write port, and it applies backpressure in both directions.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a load session (honoured only in IDLE)
- base_addr  in  ADDR_W  first write address, sampled on accepted start
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLLV, 6 SRLV, 7 MUL, 8 ADDI, 9 ANDI, 10 ORI, 11 XORI, 12 LW, 13 SW, 14 BEQ, 15 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register numbers
- in_imm  in  16  immediate / offset, passed through verbatim
- in_last  in  1  marks final request of the session
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_addr  out  ADDR_W  word address for out_instr
- out_instr  out  32  encoded instruction
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at session end
- err_illegal  out  1  sticky: illegal op seen this session
- err_wrap  out  1  sticky: address counter wrapped this session
- count  out  ADDR_W+1  words emitted this session

## Operation
- FSM: IDLE → RUN on start; RUN → DONE when the in_last request completes; DONE → IDLE unconditionally. Completion means the output handshake for an emitted word, or acceptance for an illegal op.
- start in RUN/DONE ignored. On accepted start: next_addr←base_addr; count, err_illegal and err_wrap cleared.
- in_ready = (state==RUN) && (!out_valid || out_ready). Single output register, so full throughput is one word per cycle.
- R-type (ops 0–7): [31:26]=000000, [25:21]=rs1, [20:16]=rs2, [15:11]=rd, [10:6]=0, funct: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLLV 000100, SRLV 000110, MUL 011000.
- I-type: [31:26]=opcode, [25:21]=rs1, [15:0]=imm. [20:16]: rd for ADDI 001000, ANDI 001100, ORI 001101, XORI 001110 and LW 100011; rs2 for SW 101011 and BEQ 000100.
- Unused input fields are ignored.
- Accepted legal op: out_instr/out_addr loaded, out_valid←1, next_addr←next_addr+1 (mod 2^ADDR_W). If next_addr was all-ones, err_wrap←1.
- count increments on each output handshake.
- Accepted op 15: nothing emitted, next_addr unchanged, err_illegal←1.
- out_valid clears on handshake unless a new request is accepted in the same cycle.

## Timing
- Reset values: in_ready 0, out_valid 0, out_addr 0, out_instr 0, busy 0, done 0, err_illegal 0, err_wrap 0, count 0, state IDLE, next_addr 0.
- Latency: accept in cycle N → out_valid in cycle N+1.
- out_instr and out_addr are held stable while out_valid && !out_ready.
- done asserts in the cycle after the completing event; busy drops in the same cycle. The error flags and count hold until the next start.
- Reset mid-session: pending word is discarded and all outputs return to reset values immediately, independent of clk.

## Test plan
- start base_addr=0x010, ADD rd3 rs1 1 rs2 2 → out_instr 0x00221820 at out_addr 0x010, one cycle after accept.
- Stream ADDI rd5 rs0 imm 0x0010, LW rd4 rs1 29 imm 0xFFF8, SW rs2 4 rs1 29 imm 0, BEQ rs1 1 rs2 2 imm 3, MUL rd3 rs1 1 rs2 2 (last) with out_ready=1 → 0x20050010, 0x8FA4FFF8, 0xAFA40000, 0x10220003, 0x00221818 back-to-back. Addresses increase by one each word, count=5, done pulses once.
- Hold out_ready=0 for 3 cycles with a word pending → in_ready=0, out_instr/out_addr unchanged, no request lost or duplicated.
- Op 15 between two ADDs → err_illegal=1, the two ADDs land at consecutive addresses, count=2.
- ADDR_W=2, base_addr=3, two ADDs → out_addr 3 then 0, err_wrap=1.
- rst_n low while out_valid=1 in RUN → all outputs at reset values at once. A later start works normally, and start pulsed during RUN has no effect.
